// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with sequence lock tracking and error counter
// Decodes a Johnson word to its state index and follows a counter's progress through UNLOCKED/CHECK/LOCKED.
module johnson_decoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_code,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam int NSTATES = 2 * WIDTH;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             hit;
  logic [IDX_W-1:0] dec;
  logic [IDX_W-1:0] succ;

  // Code k: low k bits set up to k=WIDTH, then ones drain out from the bottom.
  function automatic logic [WIDTH-1:0] jcode(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      c[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
    end
    return c;
  endfunction

  always_comb begin
    hit = 1'b0;
    dec = '0;
    for (int k = 0; k < NSTATES; k++) begin
      if (in_code == jcode(k)) begin
        hit = 1'b1;
        dec = IDX_W'(k);
      end
    end
  end

  assign succ = (prev_q == IDX_W'(NSTATES - 1)) ? '0 : prev_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      idx_valid_d = 1'b1;
      if (!hit) begin
        illegal_d = 1'b1;
        state_d   = UNLOCKED;
      end else begin
        idx_d  = dec;
        prev_d = dec;
        unique case (state_q)
          UNLOCKED: state_d = CHECK;
          CHECK: begin
            if (dec == succ) state_d = LOCKED;
          end
          LOCKED: begin
            // A repeated word means the counter is stalled, which is not an error.
            if ((dec != succ) && (dec != prev_q)) begin
              seq_err_d = 1'b1;
              state_d   = CHECK;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end

    if (clr_err) begin
      err_cnt_d = '0;
    end else if ((illegal_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - self-checking bench for johnson_decoder (WIDTH=4)
// A behavioural model tracks lock progress; a negedge process compares every cycle.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_code = 4'b0000;
  logic       in_valid = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] idx;
  logic       idx_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;

  int m_idx = 0;
  int m_prev = 0;
  bit m_have = 1'b0;
  bit m_locked = 1'b0;
  bit m_valid = 1'b0;
  bit m_ill = 1'b0;
  bit m_seq = 1'b0;
  int m_err = 0;

  johnson_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_code  (in_code),
    .in_valid (in_valid),
    .clr_err  (clr_err),
    .idx      (idx),
    .idx_valid(idx_valid),
    .illegal  (illegal),
    .seq_err  (seq_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mcode(input int k);
    if (k <= 4) return 4'((1 << k) - 1);
    return 4'(15 & ~((1 << (k - 4)) - 1));
  endfunction

  task automatic model_reset();
    m_idx = 0; m_prev = 0; m_have = 1'b0; m_locked = 1'b0;
    m_valid = 1'b0; m_ill = 1'b0; m_seq = 1'b0; m_err = 0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic v, input logic cl);
    int k;
    int nxt;
    k = -1;
    for (int i = 0; i < 8; i++) if (mcode(i) == c) k = i;
    m_valid = v; m_ill = 1'b0; m_seq = 1'b0;
    if (v) begin
      if (k < 0) begin
        m_ill = 1'b1; m_have = 1'b0; m_locked = 1'b0;
      end else begin
        nxt = (m_prev + 1) % 8;
        m_idx = k;
        if (!m_have) m_have = 1'b1;
        else if (!m_locked) begin
          if (k == nxt) m_locked = 1'b1;
        end else if (k != nxt && k != m_prev) begin
          m_seq = 1'b1; m_locked = 1'b0;
        end
        m_prev = k;
      end
    end
    if (cl) m_err = 0;
    else if ((m_ill || m_seq) && m_err < 255) m_err++;
  endtask

  always @(negedge clk) begin
    chk("cyc_idx", int'(idx), m_idx);
    chk("cyc_idx_valid", int'(idx_valid), int'(m_valid));
    chk("cyc_illegal", int'(illegal), int'(m_ill));
    chk("cyc_seq_err", int'(seq_err), int'(m_seq));
    chk("cyc_locked", int'(locked), int'(m_locked));
    chk("cyc_err_cnt", int'(err_cnt), m_err);
  end

  task automatic step(input logic [3:0] c, input logic v, input logic cl);
    in_code = c; in_valid = v; clr_err = cl;
    @(posedge clk);
    model_step(c, v, cl);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"}, int'(idx), 0);
    chk({tag, "_idx_valid"}, int'(idx_valid), 0);
    chk({tag, "_illegal"}, int'(illegal), 0);
    chk({tag, "_seq_err"}, int'(seq_err), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    model_reset();
    #1 chk_all_zero("rst0");
    @(negedge clk);
    rst = 1'b1;

    step(4'b0000, 1'b1, 1'b0);
    chk("a_idx0", int'(idx), 0); chk("a_vld", int'(idx_valid), 1); chk("a_lk0", int'(locked), 0);
    step(4'b0001, 1'b1, 1'b0);
    chk("a_idx1", int'(idx), 1); chk("a_lk1", int'(locked), 1);
    step(4'b0011, 1'b1, 1'b0);
    chk("a_idx2", int'(idx), 2);
    step(4'b0111, 1'b1, 1'b0);
    chk("a_idx3", int'(idx), 3); chk("a_err0", int'(err_cnt), 0);

    step(4'b1111, 1'b1, 1'b0);
    step(4'b1110, 1'b1, 1'b0);
    step(4'b1100, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk("w_idx7", int'(idx), 7);
    step(4'b0000, 1'b1, 1'b0);
    chk("w_idx0", int'(idx), 0); chk("w_lk", int'(locked), 1); chk("w_seq", int'(seq_err), 0);

    step(4'b0001, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    step(4'b1110, 1'b1, 1'b0);
    chk("s_seq", int'(seq_err), 1); chk("s_err", int'(err_cnt), 1);
    chk("s_lk", int'(locked), 0); chk("s_idx", int'(idx), 5);
    step(4'b1100, 1'b1, 1'b0);
    chk("s_relk", int'(locked), 1); chk("s_seq0", int'(seq_err), 0); chk("s_idx6", int'(idx), 6);
    step(4'b0000, 1'b0, 1'b0);
    chk("i_vld0", int'(idx_valid), 0); chk("i_idx", int'(idx), 6);
    step(4'b1100, 1'b1, 1'b0);
    chk("h_lk", int'(locked), 1); chk("h_seq", int'(seq_err), 0); chk("h_err", int'(err_cnt), 1);

    step(4'b0101, 1'b1, 1'b0);
    chk("x_ill", int'(illegal), 1); chk("x_idx", int'(idx), 6);
    chk("x_lk", int'(locked), 0); chk("x_err", int'(err_cnt), 2);

    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 4'b1010 : 4'b0110, 1'b1, 1'b0);
    chk("sat_err", int'(err_cnt), 255);
    step(4'b1011, 1'b1, 1'b1);
    chk("clr_err", int'(err_cnt), 0); chk("clr_ill", int'(illegal), 1);

    step(4'b0000, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    chk("r_lk", int'(locked), 1);
    step(4'b0011, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1 chk_all_zero("rstmid");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    step(4'b0011, 1'b1, 1'b0);
    chk("rl_idx2", int'(idx), 2); chk("rl_lk0", int'(locked), 0);
    step(4'b0111, 1'b1, 1'b0);
    chk("rl_idx3", int'(idx), 3); chk("rl_lk1", int'(locked), 1);
    step(4'b0000, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the Johnson code width in bits; legal range 2..16.
REQ-002 The block SHALL have derived parameter IDX_W, default 3, equal to ceil(log2(2*WIDTH)); it is not overridden by the user.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 The block SHALL have port in_code, input, WIDTH, the Johnson code word from a johnson_counter out.
REQ-006 The block SHALL have port in_valid, input, 1; in_code is sampled on rising clk only while in_valid=1.
REQ-007 The block SHALL have port clr_err, input, 1, synchronous clear of err_cnt.
REQ-008 The block SHALL have port idx, output, IDX_W, the decoded state index 0..2*WIDTH-1.
REQ-009 The block SHALL have port idx_valid, output, 1, a one-cycle pulse per sampled word, legal or not.
REQ-010 The block SHALL have port illegal, output, 1, a one-cycle pulse when the sampled word is not a legal Johnson code.
REQ-011 The block SHALL have port seq_err, output, 1, a one-cycle pulse on a legal but out-of-sequence word while locked.
REQ-012 The block SHALL have port locked, output, 1, high while the FSM is in LOCKED.
REQ-013 The block SHALL have port err_cnt, output, 8, the saturating count of illegal and seq_err events.

Function
REQ-014 The block SHALL define legal code k, for k in 0..WIDTH, as the low k bits set; for k in WIDTH+1..2*WIDTH-1 it SHALL be the high 2*WIDTH-k bits set. For WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000 map to 0..7.
REQ-015 All outputs SHALL be registered, with 1-cycle latency: a word sampled at edge N produces idx, idx_valid, illegal and seq_err after edge N; the pulses SHALL clear at edge N+1 unless a new sample occurs.
REQ-016 On a legal word, idx SHALL update to k; on an illegal word, idx SHALL hold its previous value.
REQ-017 The FSM SHALL have exactly three states: UNLOCKED, CHECK and LOCKED; prev holds the last legal idx.
REQ-018 In UNLOCKED: a legal word SHALL move the FSM to CHECK and load prev; an illegal word SHALL keep it in UNLOCKED with illegal pulsed.
REQ-019 In CHECK: a legal word equal to (prev+1) mod 2*WIDTH SHALL move the FSM to LOCKED; any other legal word SHALL stay in CHECK and reload prev; an illegal word SHALL move to UNLOCKED. No seq_err SHALL be raised in CHECK.
REQ-020 In LOCKED, for each input case:
 - successor word: stay in LOCKED;
 - word equal to prev (counter held in reset/stall): stay in LOCKED, no error;
 - other legal word: pulse seq_err, move to CHECK, reload prev;
 - illegal word: pulse illegal, move to UNLOCKED, seq_err=0.
REQ-021 Wrap-around from 2*WIDTH-1 to 0 SHALL count as the successor.
REQ-022 err_cnt SHALL increment by 1 on each cycle with illegal or seq_err set, SHALL saturate at 255, and SHALL never wrap.
REQ-023 clr_err=1 SHALL zero err_cnt at the next edge; clear SHALL take priority over a simultaneous error event.
REQ-024 While in_valid=0, the FSM, prev, idx and err_cnt SHALL hold, and all pulses SHALL be 0.

Reset
REQ-025 rst=0 SHALL immediately force idx=0, idx_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0, prev=0 and the FSM to UNLOCKED, independent of clk.
REQ-026 The first rising clk with rst=1 SHALL be able to sample in_code normally.
REQ-027 Reset asserted mid-sequence SHALL discard lock; relock SHALL require two consecutive successive legal words.

Verification
REQ-028 Reset released, WIDTH=4, feed 0000,0001,0011,0111 -> idx 0,1,2,3; locked=1 after the second sample; err_cnt=0.
REQ-029 Locked at 1000 (idx 7), feed 0000 -> idx=0, locked stays 1, no seq_err.
REQ-030 Locked at 0011, feed 1110 -> seq_err one cycle, err_cnt=1, locked=0 (CHECK); feed 1100 -> locked=1.
REQ-031 Feed 0101 while locked -> illegal one cycle, idx unchanged, locked=0, err_cnt+1.
REQ-032 Feed 300 illegal words -> err_cnt=255; clr_err together with an illegal word -> err_cnt=0.
REQ-033 Locked, drive rst=0 between clock edges -> all outputs 0 at once; after release, relock needs two successive words.
